// File: rtl/uop_sequencer_p_pkg.sv
// -----------------------------------------------------------------------------
// uop_sequencer_p_pkg
// Shared definitions for the micro-op sequencer:
//   - seq_state_t : sequencer FSM encoding (IDLE=0, RUN=1)
//   - DEF_*       : default parameter values
//   - zext_next   : how the control-store next-micro-address field is widened
//                   to a full control-store address (plain zero extension)
// -----------------------------------------------------------------------------
package uop_sequencer_p_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    localparam int DEF_UADDR_W  = 8;
    localparam int DEF_NEXT_W   = 7;
    localparam int DEF_MAX_UOPS = 16;
    localparam int DEF_REP_W    = 32;

    // Keep only the low next_w bits of the field; everything above is zero.
    // The caller resizes the 32-bit result to its address width.
    function automatic logic [31:0] zext_next(input logic [31:0] next_field,
                                              input int          next_w);
        logic [31:0] mask;
        mask = (next_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << next_w) - 32'd1);
        return next_field & mask;
    endfunction

endpackage

// File: rtl/uop_sequencer_p_rep_counter.sv
// -----------------------------------------------------------------------------
// uop_rep_counter
// REP iteration down-counter. Loads the iteration count when an instruction is
// accepted and decrements once per completed iteration. It saturates at zero
// so the count can never wrap.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : load i_load_val (has priority over i_dec)
//   i_load_val   : iteration count to load
//   i_dec        : decrement by one (ignored when already zero)
//   o_count      : current count
//   o_is_one     : count == 1
//   o_is_zero    : count == 0
// -----------------------------------------------------------------------------
module uop_rep_counter #(
    parameter int REP_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [REP_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [REP_W-1:0] o_count,
    output logic             o_is_one,
    output logic             o_is_zero
);

    logic [REP_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - REP_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_is_one  = (r_count == REP_W'(1));
    assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/uop_sequencer_p.sv
// -----------------------------------------------------------------------------
// uop_sequencer_p
// Micro-op sequencer between decode stage 1 and the control-store lookup.
// Accepts one instruction at a time and emits one control-store address per
// cycle, walking multi-uop instructions via the external control store
// (cs_more / cs_next_addr answer combinationally for out_addr) and replaying
// the body for REP prefixes.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. valid, once raised, is held with stable data
// until the transfer; ready may depend combinationally on the other side.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : instruction handshake from decode stage 1
//   in_addr, in_opsize         : first-uop address and its opsize
//   in_rep_en, in_rep_count    : REP prefix and iteration count
//   cs_more, cs_next_addr      : control word for out_addr (another uop follows
//                                / next micro-address field)
//   flush                      : drop everything, return to IDLE
//   out_valid/out_ready        : uop handshake to the AG latch
//   out_addr, out_opsize       : control-store address and opsize (first uop only)
//   out_first, out_last, out_idx : uop position within the instruction
//   rep_skip                   : pulse, REP accepted with count 0
//   uop_err                    : pulse, MAX_UOPS overflow
//   o_dbg_state                : current FSM state
// -----------------------------------------------------------------------------
module uop_sequencer_p
    import uop_sequencer_p_pkg::*;
#(
    parameter int UADDR_W  = DEF_UADDR_W,
    parameter int NEXT_W   = DEF_NEXT_W,
    parameter int MAX_UOPS = DEF_MAX_UOPS,
    parameter int REP_W    = DEF_REP_W,
    localparam int IDX_W   = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [UADDR_W-1:0] in_addr,
    input  logic               in_opsize,
    input  logic               in_rep_en,
    input  logic [REP_W-1:0]   in_rep_count,
    input  logic               cs_more,
    input  logic [NEXT_W-1:0]  cs_next_addr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [UADDR_W-1:0] out_addr,
    output logic               out_opsize,
    output logic               out_first,
    output logic               out_last,
    output logic [IDX_W-1:0]   out_idx,
    output logic               rep_skip,
    output logic               uop_err,
    output seq_state_t         o_dbg_state
);

    // ---------------- registers ----------------
    seq_state_t         r_state;
    logic [UADDR_W-1:0] r_addr;
    logic               r_opsize;
    logic [IDX_W-1:0]   r_idx;
    logic               r_first;
    logic [UADDR_W-1:0] r_base_addr;
    logic               r_base_opsize;
    logic               r_rep_active;
    logic               r_rep_skip;
    logic               r_uop_err;

    // ---------------- next-state wires ----------------
    seq_state_t         w_nxt_state;
    logic [UADDR_W-1:0] w_nxt_addr;
    logic               w_nxt_opsize;
    logic [IDX_W-1:0]   w_nxt_idx;
    logic               w_nxt_first;
    logic [UADDR_W-1:0] w_nxt_base_addr;
    logic               w_nxt_base_opsize;
    logic               w_nxt_rep_active;
    logic               w_nxt_rep_skip;
    logic               w_nxt_uop_err;
    logic               w_rep_load;
    logic               w_rep_dec;

    // ---------------- decode wires ----------------
    logic               w_out_valid;
    logic               w_fire_in;
    logic               w_fire_out;
    logic               w_idx_max;
    logic               w_ovf;
    logic               w_uop_last;
    logic               w_iter_last;
    logic               w_end;
    logic               w_iter_done;
    logic               w_rep_zero_req;
    logic [UADDR_W-1:0] w_next_ext;
    logic [REP_W-1:0]   w_rep_count;
    logic               w_rep_one;
    logic               w_rep_zero;

    uop_rep_counter #(
        .REP_W (REP_W)
    ) u_rep_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_rep_load),
        .i_load_val (in_rep_count),
        .i_dec      (w_rep_dec),
        .o_count    (w_rep_count),
        .o_is_one   (w_rep_one),
        .o_is_zero  (w_rep_zero)
    );

    assign w_next_ext  = UADDR_W'(zext_next(32'(cs_next_addr), NEXT_W));

    assign w_out_valid = (r_state == ST_RUN);
    assign w_idx_max   = (r_idx == IDX_W'(MAX_UOPS - 1));
    // Overflow: the control word still asks for more but the index is used up.
    assign w_ovf       = cs_more & w_idx_max;
    assign w_uop_last  = !cs_more | w_idx_max;
    // Overflow terminates the instruction and discards remaining iterations.
    // The zero term only guards against a counter that somehow reached zero.
    assign w_iter_last = !r_rep_active | w_rep_one | w_rep_zero | w_ovf;

    assign w_fire_out  = w_out_valid & out_ready;
    assign w_end       = w_fire_out & w_uop_last;
    assign w_iter_done = w_end & w_iter_last;

    assign in_ready    = !flush & ((r_state == ST_IDLE) | w_iter_done);
    assign w_fire_in   = in_valid & in_ready;
    assign w_rep_zero_req = in_rep_en & (in_rep_count == '0);

    // ---------------- next-state logic ----------------
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_addr        = r_addr;
        w_nxt_opsize      = r_opsize;
        w_nxt_idx         = r_idx;
        w_nxt_first       = r_first;
        w_nxt_base_addr   = r_base_addr;
        w_nxt_base_opsize = r_base_opsize;
        w_nxt_rep_active  = r_rep_active;
        w_nxt_rep_skip    = 1'b0;
        w_nxt_uop_err     = 1'b0;
        w_rep_load        = 1'b0;
        w_rep_dec         = 1'b0;

        if (flush) begin
            // The presented uop is dropped even if out_ready is high.
            w_nxt_state      = ST_IDLE;
            w_nxt_idx        = '0;
            w_nxt_rep_active = 1'b0;
            w_nxt_first      = 1'b0;
        end else begin
            if (w_fire_out) begin
                w_nxt_uop_err = w_ovf;
                if (!w_end) begin
                    // Continue the current iteration.
                    w_nxt_addr   = w_next_ext;
                    w_nxt_opsize = 1'b0;
                    w_nxt_idx    = r_idx + IDX_W'(1);
                    w_nxt_first  = 1'b0;
                end else if (!w_iter_done) begin
                    // Replay the body for the next REP iteration.
                    w_nxt_addr   = r_base_addr;
                    w_nxt_opsize = r_base_opsize;
                    w_nxt_idx    = '0;
                    w_nxt_first  = 1'b1;
                    w_rep_dec    = 1'b1;
                end else begin
                    w_nxt_state      = ST_IDLE;
                    w_nxt_rep_active = 1'b0;
                end
            end

            // in_ready guarantees this only happens from IDLE or on iter_done,
            // so it overrides the instruction-end branch above without a bubble.
            if (w_fire_in) begin
                if (w_rep_zero_req) begin
                    w_nxt_rep_skip   = 1'b1;
                    w_nxt_state      = ST_IDLE;
                    w_nxt_rep_active = 1'b0;
                end else begin
                    w_nxt_state       = ST_RUN;
                    w_nxt_addr        = in_addr;
                    w_nxt_opsize      = in_opsize;
                    w_nxt_idx         = '0;
                    w_nxt_first       = 1'b1;
                    w_nxt_base_addr   = in_addr;
                    w_nxt_base_opsize = in_opsize;
                    w_nxt_rep_active  = in_rep_en;
                    w_rep_load        = 1'b1;
                end
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_opsize      <= 1'b0;
            r_idx         <= '0;
            r_first       <= 1'b0;
            r_base_addr   <= '0;
            r_base_opsize <= 1'b0;
            r_rep_active  <= 1'b0;
            r_rep_skip    <= 1'b0;
            r_uop_err     <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_addr        <= w_nxt_addr;
            r_opsize      <= w_nxt_opsize;
            r_idx         <= w_nxt_idx;
            r_first       <= w_nxt_first;
            r_base_addr   <= w_nxt_base_addr;
            r_base_opsize <= w_nxt_base_opsize;
            r_rep_active  <= w_nxt_rep_active;
            r_rep_skip    <= w_nxt_rep_skip;
            r_uop_err     <= w_nxt_uop_err;
        end
    end

    // ---------------- outputs ----------------
    assign out_valid   = w_out_valid;
    assign out_addr    = r_addr;
    assign out_opsize  = r_opsize;
    assign out_first   = r_first;
    assign out_idx     = r_idx;
    assign out_last    = w_out_valid & w_uop_last & w_iter_last;
    assign rep_skip    = r_rep_skip;
    assign uop_err     = r_uop_err;
    assign o_dbg_state = r_state;

    // The full count is only consumed through the is_one/is_zero flags.
    logic w_unused_count;
    assign w_unused_count = ^w_rep_count;

endmodule

// File: tb/tb_uop_sequencer_p.sv
module tb_uop_sequencer_p;

  localparam int MAXU = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_addr;
  logic        in_opsize;
  logic        in_rep_en;
  logic [31:0] in_rep_count;
  logic        cs_more;
  logic [6:0]  cs_next_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_addr;
  logic        out_opsize;
  logic        out_first;
  logic        out_last;
  logic [1:0]  out_idx;
  logic        rep_skip;
  logic        uop_err;
  uop_sequencer_p_pkg::seq_state_t dbg_state;

  // control-store model: answers combinationally for out_addr
  logic       rom_more [256];
  logic [6:0] rom_next [256];
  assign cs_more      = rom_more[out_addr];
  assign cs_next_addr = rom_next[out_addr];

  uop_sequencer_p #(
    .UADDR_W (8),
    .NEXT_W  (7),
    .MAX_UOPS(MAXU),
    .REP_W   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_opsize   (in_opsize),
    .in_rep_en   (in_rep_en),
    .in_rep_count(in_rep_count),
    .cs_more     (cs_more),
    .cs_next_addr(cs_next_addr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_opsize  (out_opsize),
    .out_first   (out_first),
    .out_last    (out_last),
    .out_idx     (out_idx),
    .rep_skip    (rep_skip),
    .uop_err     (uop_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  addr;
    logic        opsize;
    logic        first;
    logic [1:0]  idx;
    logic        last;
    logic        ovf;
    int unsigned id;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_uops  = 0;
  int n_skip  = 0;
  int n_err   = 0;
  int unsigned next_id = 0;
  logic pend_skip = 1'b0;
  logic pend_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected uop stream of one instruction, walked straight from the
  // control-store contents: each iteration starts at the instruction address
  // and follows next-address links until a word without "more" or until
  // MAXU uops; overflow ends the whole instruction.
  function automatic void expand(input logic [7:0] a0, input logic op, input logic re,
                                 input logic [31:0] cnt, input int unsigned id);
    int iters;
    logic [7:0] a;
    exp_t e;
    logic stop;
    logic ovf;
    if (re && cnt == 0) return;
    iters = re ? int'(cnt) : 1;
    for (int it = 0; it < iters; it++) begin
      a = a0;
      for (int k = 0; k < MAXU; k++) begin
        ovf  = rom_more[a] && (k == MAXU - 1);
        stop = !rom_more[a] || (k == MAXU - 1);
        e.addr   = a;
        e.opsize = (k == 0) ? op : 1'b0;
        e.first  = (k == 0);
        e.idx    = 2'(k);
        e.last   = stop && ((it == iters - 1) || ovf);
        e.ovf    = ovf;
        e.id     = id;
        exp_q.push_back(EXP_W'(e));
        if (ovf) return;
        if (stop) break;
        a = {1'b0, rom_next[a]};
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    exp_t f;
    if (reset) begin
      pend_skip = 1'b0;
      pend_err  = 1'b0;
    end else begin
      chk("rep_skip", {31'b0, rep_skip}, {31'b0, pend_skip});
      chk("uop_err", {31'b0, uop_err}, {31'b0, pend_err});
      if (rep_skip) n_skip++;
      if (uop_err) n_err++;
      pend_skip = 1'b0;
      pend_err  = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_uop", {24'b0, out_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_t'(exp_q[0]);
          chk("in_ready_run", {31'b0, in_ready}, {31'b0, !flush && out_ready && e.last});
          if (flush) begin
            while (exp_q.size() > 0) begin
              f = exp_t'(exp_q[0]);
              if (f.id != e.id) break;
              void'(exp_q.pop_front());
            end
          end else if (out_ready) begin
            chk("out_addr", {24'b0, out_addr}, {24'b0, e.addr});
            chk("out_opsize", {31'b0, out_opsize}, {31'b0, e.opsize});
            chk("out_first", {31'b0, out_first}, {31'b0, e.first});
            chk("out_idx", {30'b0, out_idx}, {30'b0, e.idx});
            chk("out_last", {31'b0, out_last}, {31'b0, e.last});
            pend_err = e.ovf;
            n_uops++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("in_ready_idle", {31'b0, in_ready}, {31'b0, !flush});
      end
      if (in_valid && in_ready) begin
        if (in_rep_en && in_rep_count == 0) pend_skip = 1'b1;
        else expand(in_addr, in_opsize, in_rep_en, in_rep_count, next_id);
        next_id++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic op, input logic re, input logic [31:0] cnt);
    int waited;
    @(posedge clk); #1;
    in_valid = 1'b1; in_addr = a; in_opsize = op; in_rep_en = re; in_rep_count = cnt;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("send_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_idle", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_u;
    int base_s;
    int base_e;
    logic accepted;
    int issued;
    int cyc;

    for (int i = 0; i < 256; i++) begin
      rom_more[i] = 1'b0;
      rom_next[i] = 7'h0;
    end
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_opsize = 1'b0; in_rep_en = 1'b0;
    in_rep_count = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_addr", {24'b0, out_addr}, 32'd0);
    chk("rst_out_opsize", {31'b0, out_opsize}, 32'd0);
    chk("rst_out_first", {31'b0, out_first}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_out_idx", {30'b0, out_idx}, 32'd0);
    chk("rst_dbg_state", {31'b0, dbg_state}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // single uop
    send(8'h3A, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("single_valid", {31'b0, out_valid}, 32'd1);
    chk("single_addr", {24'b0, out_addr}, 32'h3A);
    chk("single_first", {31'b0, out_first}, 32'd1);
    chk("single_last", {31'b0, out_last}, 32'd1);
    chk("single_in_ready", {31'b0, in_ready}, 32'd1);
    wait_idle();

    // three uops
    rom_more[8'h10] = 1'b1; rom_next[8'h10] = 7'h41;
    rom_more[8'h41] = 1'b1; rom_next[8'h41] = 7'h42;
    rom_more[8'h42] = 1'b0;
    base_u = n_uops;
    send(8'h10, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("three_addr0", {24'b0, out_addr}, 32'h10);
    chk("three_op0", {31'b0, out_opsize}, 32'd1);
    chk("three_last0", {31'b0, out_last}, 32'd0);
    @(negedge clk);
    chk("three_addr1", {24'b0, out_addr}, 32'h41);
    chk("three_op1", {31'b0, out_opsize}, 32'd0);
    chk("three_idx1", {30'b0, out_idx}, 32'd1);
    @(negedge clk);
    chk("three_addr2", {24'b0, out_addr}, 32'h42);
    chk("three_idx2", {30'b0, out_idx}, 32'd2);
    chk("three_last2", {31'b0, out_last}, 32'd1);
    wait_idle();
    chk("three_count", n_uops - base_u, 32'd3);

    // REP x3 over a two-uop body
    rom_more[8'h20] = 1'b1; rom_next[8'h20] = 7'h21;
    rom_more[8'h21] = 1'b0;
    base_u = n_uops;
    send(8'h20, 1'b1, 1'b1, 32'd3);
    wait_idle();
    chk("rep3_count", n_uops - base_u, 32'd6);

    // REP with count 0
    base_u = n_uops; base_s = n_skip;
    send(8'h3A, 1'b0, 1'b1, 32'd0);
    wait_idle();
    chk("rep0_uops", n_uops - base_u, 32'd0);
    chk("rep0_skip", n_skip - base_s, 32'd1);

    // stall four cycles mid-sequence
    base_u = n_uops;
    send(8'h10, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_addr", {24'b0, out_addr}, 32'h41);
      chk("stall_idx", {30'b0, out_idx}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();
    chk("stall_count", n_uops - base_u, 32'd3);

    // flush with out_valid=1 and in_valid=1
    send(8'h20, 1'b1, 1'b1, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b1; in_addr = 8'h3A; in_opsize = 1'b1; in_rep_en = 1'b0; in_rep_count = 32'd0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_reaccept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_new_addr", {24'b0, out_addr}, 32'h3A);
    wait_idle();

    // overflow: more stuck at 1; REP remainder discarded
    for (int i = 0; i < 4; i++) begin
      rom_more[8'h50 + i] = 1'b1;
      rom_next[8'h50 + i] = 7'(8'h51 + i);
    end
    base_u = n_uops; base_e = n_err;
    send(8'h50, 1'b1, 1'b1, 32'd2);
    wait_idle();
    chk("ovf_count", n_uops - base_u, 32'd4);
    chk("ovf_err", n_err - base_e, 32'd1);

    // randomized traffic with stalls and flushes
    for (int i = 0; i < 256; i++) begin
      rom_more[i] = ($urandom_range(0, 9) < 6);
      rom_next[i] = 7'($urandom_range(0, 127));
    end
    accepted = 1'b0;
    issued = 0;
    cyc = 0;
    while ((issued < 60 || in_valid) && cyc < 8000) begin
      @(posedge clk); #1;
      if (accepted) begin
        in_valid = 1'b0;
        accepted = 1'b0;
      end
      if (!in_valid && issued < 60 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_addr = 8'($urandom_range(0, 255));
        in_opsize = 1'($urandom_range(0, 1));
        in_rep_en = ($urandom_range(0, 2) == 0);
        in_rep_count = in_rep_en ? 32'($urandom_range(0, 3)) : $urandom;
        issued++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      if (in_valid && in_ready) accepted = 1'b1;
      cyc++;
    end
    chk("random_issue_done", {31'b0, in_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
